// File: rtl/fsm_step_pkg.sv
// Purpose: shared constants and the state encoding for the step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fsm_step_pkg;

  // Width of every internal cycle counter (debounce, arm-settle, tick).
  localparam int CNT_W = 32;

  // Encoding is visible on the mode output, so values are fixed.
  typedef enum logic [1:0] {
    ST_PAUSE = 2'b00,
    ST_RUN   = 2'b01,
    ST_HOLD  = 2'b10
  } state_t;

endpackage

// File: rtl/fsm_step_controller_debouncer.sv
// Purpose: 2-flop synchroniser followed by a consecutive-sample debouncer.
// Latency: 2 cycles to synchronise, then DEBOUNCE_CYCLES stable samples to accept a level.
// Backpressure: none; free-running level filter.
//
// Ports: clk (board clock), reset (sync, active-low), din (raw async level),
//        dout (debounced level, registered, 0 after reset).
module debouncer
  import fsm_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      // The counter only runs while the synchronised level disagrees with
      // the accepted one; any agreeing sample restarts the qualification.
      if (sync2 != dout) begin
        if (cnt == LAST) begin
          dout <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/fsm_step_controller.sv
// Purpose: turns debounced button/run-switch inputs into single-cycle step_en pulses.
// Latency: button/run edge to output DEBOUNCE_CYCLES+3 cycles; auto-run step P cycles after RUN entry.
// Backpressure: none; step_en is a fire-and-forget clock enable.
//
// Ports: clk, reset (sync, active-low); btn_step, sw_run, sw_in (raw async inputs);
//        rate_sel (quasi-static, P = TICK_BASE >> rate_sel);
//        step_en (1-cycle pulse), in_sampled (sw_in captured at the step),
//        mode (current state), step_count (steps issued, mod 256).
module fsm_step_controller
  import fsm_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_BASE       = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step,
  input  logic       sw_run,
  input  logic       sw_in,
  input  logic [1:0] rate_sel,
  output logic       step_en,
  output logic       in_sampled,
  output logic [1:0] mode,
  output logic [7:0] step_count
);

  localparam logic [CNT_W-1:0] TICK_BASE_L = CNT_W'(TICK_BASE);
  // A button held through reset reaches btn_db=1 after at most
  // DEBOUNCE_CYCLES+2 cycles; seeing it low for longer proves a real release.
  localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(DEBOUNCE_CYCLES + 2);

  logic             btn_db;
  logic             run_db;
  logic             in_sync1;
  logic             in_sync2;
  logic             btn_prev;
  logic             armed;
  logic [CNT_W-1:0] arm_cnt;
  logic [CNT_W-1:0] tick_cnt;
  logic [CNT_W-1:0] tick_nxt;
  logic [CNT_W-1:0] period;
  state_t           state;
  state_t           state_nxt;
  logic             issue;
  logic             btn_rise;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
    .clk   (clk),
    .reset (reset),
    .din   (btn_step),
    .dout  (btn_db)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .clk   (clk),
    .reset (reset),
    .din   (sw_run),
    .dout  (run_db)
  );

  assign period   = TICK_BASE_L >> rate_sel;
  assign btn_rise = btn_db && !btn_prev && armed;

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    issue     = 1'b0;
    case (state)
      ST_PAUSE: begin
        if (run_db) begin
          state_nxt = ST_RUN;
          tick_nxt  = '0;
        end else if (btn_rise) begin
          issue     = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (run_db) begin
          state_nxt = ST_RUN;
          tick_nxt  = '0;
        end else if (!btn_db) begin
          state_nxt = ST_PAUSE;
        end
      end
      ST_RUN: begin
        if (!run_db) begin
          state_nxt = ST_PAUSE;
          tick_nxt  = '0;
        end else if (tick_cnt >= period - 1'b1) begin
          // >= rather than == so a shrinking period fires at once
          // instead of letting the counter run on and wrap.
          issue    = 1'b1;
          tick_nxt = '0;
        end else begin
          tick_nxt = tick_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_PAUSE;
        tick_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_PAUSE;
      tick_cnt   <= '0;
      in_sync1   <= 1'b0;
      in_sync2   <= 1'b0;
      btn_prev   <= 1'b0;
      armed      <= 1'b0;
      arm_cnt    <= '0;
      step_en    <= 1'b0;
      in_sampled <= 1'b0;
      step_count <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      in_sync1 <= sw_in;
      in_sync2 <= in_sync1;
      btn_prev <= btn_db;
      step_en  <= issue;
      if (issue) begin
        in_sampled <= in_sync2;
        step_count <= step_count + 8'd1;
      end
      if (!armed) begin
        if (btn_db) begin
          arm_cnt <= '0;
        end else if (arm_cnt == ARM_LAST) begin
          armed <= 1'b1;
        end else begin
          arm_cnt <= arm_cnt + 1'b1;
        end
      end
    end
  end

  assign mode = state;

endmodule

// File: doc/fsm_step_controller.md
# fsm_step_controller

Sequencing controller for the lab Moore-machine datapath. It replaces the free-running divided clock with a single-cycle `step_en` clock enable on the board clock. It also owns all board-input conditioning: synchronisers and debouncers for the push-button and switches. It sits between the raw board I/O and the Moore machine / seven-segment path, and supports auto-run at a selectable rate and manual single-step.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000 (20 ms at 50 MHz). Number of consecutive stable synchronised samples needed to accept a new level; must be ≥2.
- `TICK_BASE`, default 25000000. Auto-run step period, in clk cycles, at `rate_sel`=0; must be ≥8.

Ports:
- `clk`, in, 1. Board clock; the single clock domain.
- `reset`, in, 1. Synchronous, active-low reset; all state clears on a `clk` edge while `reset`=0.
- `btn_step`, in, 1. Raw step push-button, active-high, asynchronous, bouncy.
- `sw_run`, in, 1. Raw run/pause switch (1 = run), asynchronous, bouncy.
- `sw_in`, in, 1. Raw Moore-machine input bit, asynchronous.
- `rate_sel`, in, 2. Auto-run rate. Period is P = `TICK_BASE` >> `rate_sel`. Treated as quasi-static; no synchroniser.
- `step_en`, out, 1. One-cycle pulse; the Moore machine advances on a `clk` edge where `step_en`=1.
- `in_sampled`, out, 1. Synchronised `sw_in`, captured in the same edge that asserts `step_en`; held stable until the next step.
- `mode`, out, 2. Current controller state: 00 PAUSE, 01 RUN, 10 STEP_HOLD.
- `step_count`, out, 8. Number of steps issued, modulo 256.

## Operation
- **Input conditioning.** Each raw input passes through a 2-flop synchroniser. `btn_step` and `sw_run` then go through a debouncer:
  - The counter increments while the synchronised value differs from the debounced value, and clears when they are equal.
  - When the counter equals `DEBOUNCE_CYCLES`-1 and the values still differ, the debounced value takes the synchronised value and the counter clears.
- **FSM states:**
  - **PAUSE.**
    - `run_db`=1 → RUN, with the tick counter cleared. Run has priority over a simultaneous button edge.
    - Otherwise, a rising edge of `btn_db` (debounced value 1, previous value 0) → issue a step and go to STEP_HOLD.
  - **STEP_HOLD.** Issues no steps. `btn_db`=0 → PAUSE. `run_db`=1 → RUN even while the button is held.
  - **RUN.**
    - The tick counter increments every cycle. When counter ≥ P-1, issue a step and clear the counter. Using ≥ makes a `rate_sel` change that shrinks P fire on the next cycle, never wrap.
    - `run_db`=0 → PAUSE, with the counter cleared and no step issued that cycle, even if it would have fired.
    - Button edges are ignored in RUN.
- **Issuing a step.** In the same edge: `step_en` is registered to 1 for exactly one cycle, `in_sampled` is loaded from the synchronised `sw_in`, and `step_count` increments (255 → 0 wraps).
- **Reset** (`reset`=0 at a `clk` edge): clears everything regardless of state. That includes mid-debounce and a pending tick. Cleared state:
  - FSM state = PAUSE.
  - `step_en`=0, `in_sampled`=0, `mode`=00, `step_count`=0.
  - Synchronisers, debounced values (0), previous-button register (0) and all counters.
  - A button held through the reset release does not step until it has been released and pressed again.

## Timing
- **All outputs are registered.** `mode` reflects the state after each edge.
- **Button latency.** A clean raw rising edge of `btn_step` before edge 0 gives `step_en`=1 in the cycle after edge `DEBOUNCE_CYCLES`+3 (2 sync, `DEBOUNCE_CYCLES` debounce, 1 FSM).
- **Run-entry latency.** `sw_run` takes the same path, so `mode`=01 appears after edge `DEBOUNCE_CYCLES`+3.
- **Auto-run timing.** If the state becomes RUN at edge E, the first `step_en` follows edge E+P. Subsequent steps are spaced exactly P cycles apart.
- **Glitch rejection.** A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never changes a debounced value.
- **Pulse width.** `step_en` is never high on two consecutive cycles, given P ≥ 2.

## Structure
- **Shared package `fsm_step_pkg`:**
  - State encoding constants `ST_PAUSE`=2'b00, `ST_RUN`=2'b01, `ST_HOLD`=2'b10.
  - Counter width constant 32.
- **Sub-module `debouncer`** (parameter `DEBOUNCE_CYCLES`; ports `clk`, `reset`, `din`, `dout`). It includes the 2-flop synchroniser and is instantiated twice.
- `sw_in` uses a bare 2-flop synchroniser in the top level.
- The downstream Moore machine moves to `clk` with `step_en` as its enable; the divided clock is retired.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4, `TICK_BASE`=16.
- **Reset values.** `reset`=0 for 3 cycles with all inputs 1 → `step_en`=0, `mode`=00, `step_count`=0, `in_sampled`=0. After release, with `btn_step` still held → no step.
- **Single step.** Clean `btn_step` press with `sw_in`=1 → one `step_en` pulse 7 cycles after the edge, `in_sampled`=1, `step_count`=1, `mode` 00→10. After release plus 7 cycles → `mode`=00.
- **Bounce rejection.** `btn_step` toggles every 2 cycles for 20 cycles, then holds 1 → exactly one step, `step_count`=1.
- **Auto-run rates.** `sw_run`=1 with `rate_sel`=0 → steps spaced 16 cycles apart. Switch to `rate_sel`=2 mid-count with counter ≥3 → step on the next cycle, then every 4 cycles.
- **Pause and reset in RUN.** Drop `sw_run` → after 7 cycles `mode`=00, no further steps. Assert `reset` mid-RUN → next edge `mode`=00, `step_count`=0.
- **Counter wrap.** `rate_sel`=3 (P=2), run for 512 cycles → `step_count` wraps 255→0 and ends at 0.
